// File: rtl/collision_event_unit.sv
// Pixel-rate ball/wall/hole collision detector with per-pair and per-ball frame cooldowns.
// Events reach a FWFT FIFO one cycle after detection; a full FIFO drops the event and sets sticky overflow.
module collision_event_unit #(
    parameter int NUM_BALLS       = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int COOLDOWN_FRAMES = 2,
    parameter int ID_W            = $clog2(NUM_BALLS)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 rack,
    input  logic [NUM_BALLS-1:0] balls_dr,
    input  logic [1:0]           table_dr,
    input  logic                 hole_dr,
    input  logic [2:0]           hole_id,
    output logic [NUM_BALLS-1:0] balls_in_game,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [1:0]           evt_type,
    output logic [ID_W-1:0]      evt_idA,
    output logic [ID_W-1:0]      evt_idB,
    output logic [2:0]           evt_aux,
    output logic                 overflow
);

    localparam int         NUM_PAIRS = NUM_BALLS * (NUM_BALLS - 1) / 2;
    localparam int         PTR_W     = $clog2(FIFO_DEPTH);
    localparam int         CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int         REC_W     = 5 + 2 * ID_W;
    localparam logic [2:0] CD_ARM    = 3'(COOLDOWN_FRAMES);
    localparam logic [1:0] T_BB      = 2'b01;
    localparam logic [1:0] T_WALL    = 2'b10;
    localparam logic [1:0] T_HOLE    = 2'b11;

    logic [NUM_BALLS-1:0] act;
    logic [ID_W-1:0]      id_a, id_b;
    logic                 found_a, found_b;
    int                   pair_sel;
    logic                 wall_free, pair_free;
    logic [2:0]           wall_cd [NUM_BALLS];
    logic [2:0]           pair_cd [NUM_PAIRS];

    logic                 cand_vld, arm_wall, arm_pair, pocket;
    logic [REC_W-1:0]     cand_rec;
    logic                 full, pop, push, drop;

    logic [REC_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;

    assign act = balls_dr & balls_in_game;

    // Two lowest active balls; higher overlaps are ignored this pixel.
    always_comb begin
        id_a    = '0;
        id_b    = '0;
        found_a = 1'b0;
        found_b = 1'b0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (act[i] && !found_a) begin
                id_a    = ID_W'(i);
                found_a = 1'b1;
            end else if (act[i] && !found_b) begin
                id_b    = ID_W'(i);
                found_b = 1'b1;
            end
        end
    end

    // Row-major offset into the upper triangle (a < b) of the pair matrix.
    always_comb begin
        pair_sel = int'(id_a) * NUM_BALLS - (int'(id_a) * (int'(id_a) + 1)) / 2
                   + int'(id_b) - int'(id_a) - 1;
    end

    always_comb begin
        wall_free = 1'b0;
        pair_free = 1'b0;
        for (int i = 0; i < NUM_BALLS; i++)
            if (ID_W'(i) == id_a) wall_free = (wall_cd[i] == 3'd0);
        for (int p = 0; p < NUM_PAIRS; p++)
            if (p == pair_sel) pair_free = (pair_cd[p] == 3'd0);
    end

    // A candidate on cooldown steps aside so a lower-priority eligible one can use the slot.
    always_comb begin
        cand_vld = 1'b0;
        arm_wall = 1'b0;
        arm_pair = 1'b0;
        pocket   = 1'b0;
        cand_rec = '0;
        if (hole_dr && found_a) begin
            cand_vld = 1'b1;
            pocket   = 1'b1;
            cand_rec = {T_HOLE, id_a, {ID_W{1'b0}}, hole_id};
        end else if (table_dr != 2'b00 && found_a && wall_free) begin
            cand_vld = 1'b1;
            arm_wall = 1'b1;
            cand_rec = {T_WALL, id_a, {ID_W{1'b0}}, 1'b0, table_dr};
        end else if (found_b && pair_free) begin
            cand_vld = 1'b1;
            arm_pair = 1'b1;
            cand_rec = {T_BB, id_a, id_b, 3'b000};
        end
    end

    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign pop  = (count != '0) && evt_ready && !rack;
    assign push = cand_vld && (!full || pop) && !rack;
    assign drop = cand_vld && full && !pop && !rack;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow      <= 1'b0;
            balls_in_game <= '1;
        end else if (rack) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow      <= 1'b0;
            balls_in_game <= '1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (drop) overflow <= 1'b1;
            for (int i = 0; i < NUM_BALLS; i++)
                if (push && pocket && ID_W'(i) == id_a) balls_in_game[i] <= 1'b0;
        end
    end

    // Arming on an accept overrides the same-cycle frame decrement.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_BALLS; i++) wall_cd[i] <= 3'd0;
            for (int p = 0; p < NUM_PAIRS; p++) pair_cd[p] <= 3'd0;
        end else if (rack) begin
            for (int i = 0; i < NUM_BALLS; i++) wall_cd[i] <= 3'd0;
            for (int p = 0; p < NUM_PAIRS; p++) pair_cd[p] <= 3'd0;
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (push && arm_wall && ID_W'(i) == id_a)
                    wall_cd[i] <= CD_ARM;
                else if (startOfFrame && wall_cd[i] != 3'd0)
                    wall_cd[i] <= wall_cd[i] - 3'd1;
            end
            for (int p = 0; p < NUM_PAIRS; p++) begin
                if (push && arm_pair && p == pair_sel)
                    pair_cd[p] <= CD_ARM;
                else if (startOfFrame && pair_cd[p] != 3'd0)
                    pair_cd[p] <= pair_cd[p] - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cand_rec;
    end

    assign evt_valid = (count != '0);
    assign {evt_type, evt_idA, evt_idB, evt_aux} = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_collision_event_unit.sv
// Bench for collision_event_unit: directed scenarios with literal expectations plus random
// stimulus compared every cycle against a queue/matrix model of the event rules.
module tb_collision_event_unit;
    localparam int N = 4, DEPTH = 4, CD = 2;

    typedef struct packed {
        logic [1:0] t;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] x;
    } rec_t;

    logic         clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0, rack = 1'b0;
    logic         hole_dr = 1'b0, evt_ready = 1'b0;
    logic [N-1:0] balls_dr = '0;
    logic [1:0]   table_dr = '0;
    logic [2:0]   hole_id = '0;
    logic [N-1:0] balls_in_game;
    logic         evt_valid, overflow;
    logic [1:0]   evt_type, evt_idA, evt_idB;
    logic [2:0]   evt_aux;

    int checks = 0, passed = 0;
    bit chk_en = 1'b0;

    bit   m_ig  [N];
    int   m_wcd [N];
    int   m_pcd [N][N];
    rec_t q[$];
    bit   m_ovf;

    collision_event_unit #(.NUM_BALLS(N), .FIFO_DEPTH(DEPTH), .COOLDOWN_FRAMES(CD), .ID_W(2)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .rack(rack),
        .balls_dr(balls_dr), .table_dr(table_dr), .hole_dr(hole_dr), .hole_id(hole_id),
        .balls_in_game(balls_in_game), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_type(evt_type), .evt_idA(evt_idA), .evt_idB(evt_idB), .evt_aux(evt_aux),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    task automatic head(input string nm, input logic [1:0] t, input logic [1:0] a,
                        input logic [1:0] b, input logic [2:0] x);
        chk(nm, {evt_valid, evt_type, evt_idA, evt_idB, evt_aux}, {1'b1, t, a, b, x});
    endtask

    task automatic m_clear();
        for (int i = 0; i < N; i++) begin
            m_ig[i]  = 1'b1;
            m_wcd[i] = 0;
            for (int j = 0; j < N; j++) m_pcd[i][j] = 0;
        end
        q.delete();
        m_ovf = 1'b0;
    endtask

    // Rules-level model of one clock edge.
    task automatic model_edge();
        int   ids[$];
        rec_t r;
        bit   have, pocket, arm_w, arm_p, was_full, pop;
        if (rack) begin
            m_clear();
            return;
        end
        for (int i = 0; i < N; i++) if (balls_dr[i] && m_ig[i]) ids.push_back(i);
        have = 0; pocket = 0; arm_w = 0; arm_p = 0; r = '0;
        if (hole_dr && ids.size() > 0) begin
            r.t = 2'b11; r.a = 2'(ids[0]); r.x = hole_id; have = 1; pocket = 1;
        end else if (table_dr != 0 && ids.size() > 0 && m_wcd[ids[0]] == 0) begin
            r.t = 2'b10; r.a = 2'(ids[0]); r.x = {1'b0, table_dr}; have = 1; arm_w = 1;
        end else if (ids.size() > 1 && m_pcd[ids[0]][ids[1]] == 0) begin
            r.t = 2'b01; r.a = 2'(ids[0]); r.b = 2'(ids[1]); have = 1; arm_p = 1;
        end
        was_full = (q.size() == DEPTH);
        pop = (q.size() > 0) && evt_ready;
        if (startOfFrame)
            for (int i = 0; i < N; i++) begin
                if (m_wcd[i] > 0) m_wcd[i]--;
                for (int j = 0; j < N; j++) if (m_pcd[i][j] > 0) m_pcd[i][j]--;
            end
        if (pop) void'(q.pop_front());
        if (have) begin
            if (!was_full || pop) begin
                q.push_back(r);
                if (arm_w) m_wcd[ids[0]] = CD;
                if (arm_p) m_pcd[ids[0]][ids[1]] = CD;
                if (pocket) m_ig[ids[0]] = 1'b0;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic [N-1:0] b, input logic [1:0] t, input logic h,
                          input logic [2:0] hid, input logic sof, input logic rdy, input logic rk);
        balls_dr = b; table_dr = t; hole_dr = h; hole_id = hid;
        startOfFrame = sof; evt_ready = rdy; rack = rk;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] ig;
            rec_t         h;
            for (int i = 0; i < N; i++) ig[i] = m_ig[i];
            h = (q.size() > 0) ? q[0] : '0;
            chk("cycle", {balls_in_game, evt_valid, overflow, evt_type, evt_idA, evt_idB, evt_aux},
                {ig, q.size() > 0, m_ovf, h});
        end
    end

    initial begin
        m_clear();
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        chk("reset_ig", balls_in_game, 4'hF);
        chk("reset_out", {evt_valid, overflow, evt_type, evt_idA, evt_idB, evt_aux}, '0);
        chk_en = 1'b1;

        // Two-ball overlap with frame cooldown
        set_in(4'b0000, 2'b00, 0, 0, 1, 0, 0); cyc();
        set_in(4'b0110, 2'b00, 0, 0, 0, 0, 0); repeat (3) cyc();
        head("bb_first", 2'b01, 2'd1, 2'd2, 3'd0);
        set_in(4'b0000, 2'b00, 0, 0, 0, 1, 0); cyc();
        chk("bb_single", evt_valid, 1'b0);
        set_in(4'b0000, 2'b00, 0, 0, 1, 0, 0); cyc();
        set_in(4'b0110, 2'b00, 0, 0, 0, 0, 0); repeat (2) cyc();
        chk("bb_suppressed", evt_valid, 1'b0);
        set_in(4'b0000, 2'b00, 0, 0, 1, 0, 0); cyc();
        set_in(4'b0110, 2'b00, 0, 0, 0, 0, 0); cyc();
        head("bb_refire", 2'b01, 2'd1, 2'd2, 3'd0);
        set_in(4'b0000, 2'b00, 0, 0, 0, 1, 0); cyc();

        // Wall beats pair, pair follows on the next pixel
        set_in(4'b0000, 2'b00, 0, 0, 0, 0, 1); cyc();
        set_in(4'b0011, 2'b01, 0, 0, 0, 0, 0); cyc();
        set_in(4'b0011, 2'b00, 0, 0, 0, 0, 0); cyc();
        head("wall_first", 2'b10, 2'd0, 2'd0, 3'd1);
        set_in(4'b0000, 2'b00, 0, 0, 0, 1, 0); cyc();
        head("bb_after_wall", 2'b01, 2'd0, 2'd1, 3'd0);
        cyc();
        chk("drained", evt_valid, 1'b0);

        // Pocketing ball 3
        set_in(4'b1000, 2'b00, 1, 3'd5, 0, 0, 0); cyc();
        head("hole_evt", 2'b11, 2'd3, 2'd0, 3'd5);
        chk("hole_mask", balls_in_game, 4'b0111);
        set_in(4'b0000, 2'b00, 0, 0, 0, 1, 0); cyc();
        set_in(4'b1000, 2'b10, 0, 0, 0, 0, 0); cyc();
        chk("pocketed_silent", evt_valid, 1'b0);

        // FIFO overflow
        set_in(4'b0000, 2'b00, 0, 0, 0, 0, 1); cyc();
        for (int i = 0; i < N; i++) begin
            set_in(4'(1 << i), 2'b01, 0, 0, 0, 0, 0); cyc();
        end
        set_in(4'b0000, 2'b00, 0, 0, 1, 0, 0); repeat (2) cyc();
        set_in(4'b0001, 2'b11, 0, 0, 0, 0, 0); cyc();
        chk("ovf_set", {evt_valid, overflow}, 2'b11);
        for (int i = 0; i < N; i++) begin
            head("ovf_order", 2'b10, 2'(i), 2'd0, 3'd1);
            set_in(4'b0000, 2'b00, 0, 0, 0, 1, 0); cyc();
        end
        chk("ovf_empty", {evt_valid, overflow}, 2'b01);

        // Full FIFO with simultaneous pop and push
        set_in(4'b0000, 2'b00, 0, 0, 0, 0, 1); cyc();
        chk("rack_ovf_clr", overflow, 1'b0);
        for (int i = 0; i < N; i++) begin
            set_in(4'(1 << i), 2'b01, 0, 0, 0, 0, 0); cyc();
        end
        set_in(4'b0000, 2'b00, 0, 0, 1, 0, 0); repeat (2) cyc();
        set_in(4'b0001, 2'b10, 0, 0, 0, 1, 0); cyc();
        chk("popush_ovf", overflow, 1'b0);
        for (int i = 1; i <= N; i++) begin
            head("popush_order", 2'b10, 2'(i % N), 2'd0, (i == N) ? 3'd2 : 3'd1);
            set_in(4'b0000, 2'b00, 0, 0, 0, 1, 0); cyc();
        end
        chk("popush_empty", evt_valid, 1'b0);

        // rack mid-game
        set_in(4'b0000, 2'b00, 0, 0, 0, 0, 1); cyc();
        set_in(4'b0100, 2'b00, 1, 3'd1, 0, 0, 0); cyc();
        set_in(4'b0011, 2'b00, 0, 0, 0, 0, 0); cyc();
        chk("pre_rack_mask", balls_in_game, 4'b1011);
        set_in(4'b0011, 2'b00, 0, 0, 0, 1, 1); cyc();
        chk("rack_state", {balls_in_game, evt_valid}, 5'b11110);
        set_in(4'b0011, 2'b00, 0, 0, 0, 0, 0); cyc();
        head("rack_refire", 2'b01, 2'd0, 2'd1, 3'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            logic [N-1:0] b;
            for (int i = 0; i < N; i++) b[i] = ($urandom_range(0, 3) == 0);
            set_in(b, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                   $urandom_range(0, 31) == 0, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 119) == 0);
            cyc();
        end

        // Asynchronous reset with events queued
        set_in(4'b0000, 2'b00, 0, 0, 0, 0, 1); cyc();
        set_in(4'b0011, 2'b01, 0, 0, 0, 0, 0); cyc();
        set_in(4'b0100, 2'b00, 1, 3'd6, 0, 0, 0); cyc();
        chk("pre_arst", evt_valid, 1'b1);
        chk_en = 1'b0;
        #2 resetN = 1'b0;
        #1;
        chk("arst_state", {balls_in_game, evt_valid, overflow, evt_type, evt_idA, evt_idB, evt_aux},
            {4'hF, 11'd0});
        m_clear();
        set_in(4'b0000, 2'b00, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 resetN = 1'b1;
        chk_en = 1'b1;
        set_in(4'b0011, 2'b01, 0, 0, 0, 0, 0); cyc();
        head("post_arst_wall", 2'b10, 2'd0, 2'd0, 3'd1);
        set_in(4'b0000, 2'b00, 0, 0, 0, 0, 0); repeat (2) cyc();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
